lap_mem_arbiter: RTL

Arbitrates a single-port lap-record RAM between two requesters: the stopwatch lap-capture path (writer) and the display/readback path (reader).
Maintains the RAM as a circular buffer of the most recent laps, with write pointer, occupancy count, full and overflow status.
Reads are by recency index (0 = newest lap). Sits between the stopwatch core and the lap RAM, replacing ad-hoc we/addr generation.

---
 rtl/lap_mem_arbiter_pkg.sv | 15 +
 rtl/lap_mem_arbiter_ring.sv | 62 ++++++
 rtl/lap_mem_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lap_mem_arbiter_pkg.sv
// Shared definitions for the lap-record RAM arbiter: FSM encoding and the
// default geometry agreed with the stopwatch core.
package lap_mem_arbiter_pkg;

   localparam int LAP_AW = 10;
   localparam int LAP_DW = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_RWAIT = 2'd3
   } arb_state_e;

endpackage

// File: rtl/lap_mem_arbiter_ring.sv
// Circular-buffer bookkeeping for the lap RAM: write pointer, saturating
// occupancy count, full flag and sticky overflow.
module lap_mem_arbiter_ring
   import lap_mem_arbiter_pkg::*;
#(
   parameter int AW = LAP_AW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          adv_i,
   input  logic          inc_i,
   input  logic          ovf_set_i,
   output logic [AW-1:0] wr_ptr_o,
   output logic [AW:0]   lap_count_o,
   output logic          full_o,
   output logic          ovf_o
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         // Pointer wraps naturally at 2**AW; the count saturates at DEPTH.
         if (adv_i)
            wr_ptr_d = wr_ptr_q + AW'(1);
         if (inc_i && (count_q != DEPTH))
            count_d = count_q + (AW+1)'(1);
         if (ovf_set_i)
            ovf_d = 1'b1;
      end
   end

   assign wr_ptr_o    = wr_ptr_q;
   assign lap_count_o = count_q;
   assign full_o      = (count_q == DEPTH);
   assign ovf_o       = ovf_q;

endmodule

// File: rtl/lap_mem_arbiter.sv
// Single-port lap RAM arbiter: alternating writer/reader grants, circular
// buffer of recent laps, reads addressed by recency (0 = newest).
module lap_mem_arbiter
   import lap_mem_arbiter_pkg::*;
#(
   parameter int AW        = LAP_AW,
   parameter int DW        = LAP_DW,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_req,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   output logic          wr_drop,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_idx,
   output logic          rd_ack,
   output logic [DW-1:0] rd_data,
   output logic          rd_err,
   input  logic          clr,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [AW:0]   lap_count,
   output logic          full,
   output logic          ovf
);

   arb_state_e    state_q, state_d;
   logic          clr_pend_q, clr_pend_d;
   logic          last_wr_q, last_wr_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] rd_data_q, rd_data_d;

   logic [AW-1:0] wr_ptr;
   logic          ring_clear, ring_adv, ring_inc, ring_ovf_set;
   logic          clr_eff, drop_now, rd_oor;
   logic [AW-1:0] rd_addr;

   assign clr_eff  = clr | clr_pend_q;
   assign drop_now = full & ~OVERWRITE;
   assign rd_oor   = ({1'b0, rd_idx} >= lap_count);
   assign rd_addr  = wr_ptr - AW'(1) - rd_idx;

   lap_mem_arbiter_ring #(.AW(AW)) u_ring (
      .clk_i       (clk),
      .rst_ni      (rst),
      .clear_i     (ring_clear),
      .adv_i       (ring_adv),
      .inc_i       (ring_inc),
      .ovf_set_i   (ring_ovf_set),
      .wr_ptr_o    (wr_ptr),
      .lap_count_o (lap_count),
      .full_o      (full),
      .ovf_o       (ovf)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         clr_pend_q  <= 1'b0;
         last_wr_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         clr_pend_q  <= clr_pend_d;
         last_wr_q   <= last_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_data_q   <= rd_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_pend_d  = clr_pend_q | clr;
      last_wr_d   = last_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_data_d   = rd_data_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_eff) begin
               clr_pend_d = 1'b0;
               last_wr_d  = 1'b0;
            // After a write grant a waiting reader goes first once.
            end else if (wr_req && !(last_wr_q && rd_req)) begin
               state_d   = ST_WRITE;
               last_wr_d = 1'b1;
               if (!drop_now) begin
                  mem_addr_d  = wr_ptr;
                  mem_wdata_d = wr_data;
               end
            end else if (rd_req) begin
               state_d   = ST_READ;
               last_wr_d = 1'b0;
               if (!rd_oor)
                  mem_addr_d = rd_addr;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_READ: begin
            if (rd_oor) begin
               state_d   = ST_IDLE;
               rd_data_d = '0;
            end else begin
               state_d = ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            state_d   = ST_IDLE;
            rd_data_d = mem_rdata;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ack       = (state_q == ST_WRITE);
      wr_drop      = (state_q == ST_WRITE) && drop_now;
      mem_we       = (state_q == ST_WRITE) && !drop_now;
      rd_err       = (state_q == ST_READ) && rd_oor;
      rd_ack       = rd_err || (state_q == ST_RWAIT);
      ring_clear   = (state_q == ST_IDLE) && clr_eff;
      ring_adv     = (state_q == ST_WRITE) && !drop_now;
      ring_inc     = (state_q == ST_WRITE) && !full;
      ring_ovf_set = (state_q == ST_WRITE) && full;
      // RAM data is forwarded during the ack cycle, then held in rd_data_q.
      if (state_q == ST_RWAIT)
         rd_data = mem_rdata;
      else if (rd_err)
         rd_data = '0;
      else
         rd_data = rd_data_q;
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
